// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Brief    : IF/ID pipeline register with stall hold, flush and eret bubbles,
//            fetch-fault sanitising and delay-slot tracking.
//            Optional macro IFID_RI_CHECK_EN: reserved-instruction screening.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush_exc,
    input  logic        flush_eret,
    input  logic        eret_id,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic [4:0]  exc_code_in,
    input  logic        bd_in,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic [4:0]  exc_code_out,
    output logic        bd_out,
    output logic        valid_out
);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_RI   = 5'd10;

    logic        prev_bj;
    logic [31:0] pc_d;
    logic [31:0] instr_d;
    logic [4:0]  exc_d;
    logic        bd_d;
    logic        valid_d;
    logic        prev_bj_d;
    logic        ri_miss;

`ifdef IFID_RI_CHECK_EN
    function automatic logic is_supported(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] funct;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ok;
        op    = w[31:26];
        rs    = w[25:21];
        rt    = w[20:16];
        funct = w[5:0];
        ok    = 1'b0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b,
                    6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
                    6'h18, 6'h19, 6'h1a, 6'h1b,
                    6'h10, 6'h12, 6'h11, 6'h13: ok = 1'b1;
                    default:                    ok = 1'b0;
                endcase
            end
            6'h01: ok = (rt == 5'd0) || (rt == 5'd1);
            6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
            6'h28, 6'h29, 6'h2b: ok = 1'b1;
            6'h10: ok = (rs == 5'd0) || (rs == 5'd4) ||
                        ((rs == 5'h10) && (funct == 6'h18));
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign ri_miss = !is_supported(instr_in);
`else
    // Unsupported words flow through; decode raises RI itself.
    assign ri_miss = 1'b0;
`endif

    always_comb begin
        pc_d      = pc_out;
        instr_d   = instr_out;
        exc_d     = exc_code_out;
        bd_d      = bd_out;
        valid_d   = valid_out;
        prev_bj_d = prev_bj;
        if (flush_exc || flush_eret || (!stall && eret_id)) begin
            // Bubble keeps tracking the fetch PC and never consumes a delay slot.
            pc_d      = pc_in;
            instr_d   = 32'h0;
            exc_d     = EXC_NONE;
            bd_d      = 1'b0;
            valid_d   = 1'b0;
            prev_bj_d = 1'b0;
        end else if (!stall) begin
            pc_d    = pc_in;
            valid_d = 1'b1;
            bd_d    = prev_bj;
            if (exc_code_in != EXC_NONE) begin
                instr_d   = 32'h0;
                exc_d     = exc_code_in;
                prev_bj_d = 1'b0;
            end else if (ri_miss) begin
                instr_d   = 32'h0;
                exc_d     = EXC_RI;
                prev_bj_d = 1'b0;
            end else begin
                instr_d   = instr_in;
                exc_d     = EXC_NONE;
                prev_bj_d = bd_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out       <= RESET_PC;
            instr_out    <= 32'h0;
            exc_code_out <= EXC_NONE;
            bd_out       <= 1'b0;
            valid_out    <= 1'b0;
            prev_bj      <= 1'b0;
        end else begin
            pc_out       <= pc_d;
            instr_out    <= instr_d;
            exc_code_out <= exc_d;
            bd_out       <= bd_d;
            valid_out    <= valid_d;
            prev_bj      <= prev_bj_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_reg.sv
`default_nettype none
// Testbench for if_id_reg: directed scenarios plus randomized traffic
// checked against a behavioural model of the pipeline-register rules.
module tb_if_id_reg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset, stall, flush_exc, flush_eret, eret_id, bd_in;
    logic [31:0] pc_in, instr_in;
    logic [4:0]  exc_code_in;
    logic [31:0] pc_out, instr_out;
    logic [4:0]  exc_code_out;
    logic        bd_out, valid_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [31:0] m_pc, m_instr;
    logic [4:0]  m_exc;
    logic        m_bd, m_valid, m_pbj;

    wire [70:0] dut_v = {pc_out, instr_out, exc_code_out, bd_out, valid_out};
    wire [70:0] mdl_v = {m_pc, m_instr, m_exc, m_bd, m_valid};

    if_id_reg #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush_exc(flush_exc),
        .flush_eret(flush_eret), .eret_id(eret_id), .pc_in(pc_in),
        .instr_in(instr_in), .exc_code_in(exc_code_in), .bd_in(bd_in),
        .pc_out(pc_out), .instr_out(instr_out), .exc_code_out(exc_code_out),
        .bd_out(bd_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    function automatic logic supported(input logic [31:0] w);
        logic [5:0] op, fn;
        op = w[31:26];
        fn = w[5:0];
        if (op == 6'h00)
            return fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b, 6'h00, 6'h02,
                              6'h03, 6'h08, 6'h09, 6'h18, 6'h19, 6'h1a, 6'h1b,
                              6'h10, 6'h12, 6'h11, 6'h13};
        if (op == 6'h01) return w[20:16] inside {5'd0, 5'd1};
        if (op == 6'h10) return (w[25:21] inside {5'd0, 5'd4}) || (w[25:21] == 5'h10 && fn == 6'h18);
        return op inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0a,
                          6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h20, 6'h21, 6'h23, 6'h24,
                          6'h25, 6'h28, 6'h29, 6'h2b};
    endfunction

    function automatic logic ri_check_on();
`ifdef IFID_RI_CHECK_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Drive one cycle of inputs, clock it, advance the model, settle.
    task automatic step(input logic r, fe, fr, st, ei,
                        input logic [31:0] pc, ins, input logic [4:0] ec, input logic b);
        @(negedge clk);
        reset = r; flush_exc = fe; flush_eret = fr; stall = st; eret_id = ei;
        pc_in = pc; instr_in = ins; exc_code_in = ec; bd_in = b;
        @(posedge clk);
        if (r) begin
            m_pc = RESET_PC; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0; m_pbj = 0;
        end else if (fe || fr || (!st && ei)) begin
            m_pc = pc; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0; m_pbj = 0;
        end else if (!st) begin
            m_pc = pc; m_valid = 1; m_bd = m_pbj;
            if (ec != 0) begin
                m_instr = 0; m_exc = ec; m_pbj = 0;
            end else if (ri_check_on() && !supported(ins)) begin
                m_instr = 0; m_exc = 5'd10; m_pbj = 0;
            end else begin
                m_instr = ins; m_exc = 0; m_pbj = b;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 32'h1234, 32'hdead_beef, 0, 1);
        step(1, 0, 0, 0, 0, 32'h5678, 32'h1111_1111, 0, 0);
        n_checks++;
        if (dut_v !== {RESET_PC, 32'h0, 5'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got %h want %h", dut_v, {RESET_PC, 32'h0, 5'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_basic_load();
        step(0, 0, 0, 0, 0, 32'h3000, 32'h3401_0001, 0, 0);
        n_checks++;
        if (dut_v !== {32'h3000, 32'h3401_0001, 5'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_load: got %h want %h", dut_v, {32'h3000, 32'h3401_0001, 5'd0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_delay_slot();
        step(0, 0, 0, 0, 0, 32'h3004, 32'h1000_0003, 0, 1);
        n_checks++;
        if (dut_v !== {32'h3004, 32'h1000_0003, 5'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL ds_branch: got %h want bd=0 valid=1", dut_v);
        end
        step(0, 0, 0, 0, 0, 32'h3008, 32'h3402_000a, 0, 0);
        n_checks++;
        if (dut_v !== {32'h3008, 32'h3402_000a, 5'd0, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL ds_slot: got %h want bd=1", dut_v);
        end
        step(0, 0, 0, 0, 0, 32'h300c, 32'h2403_0001, 0, 0);
        n_checks++;
        if (dut_v !== {32'h300c, 32'h2403_0001, 5'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL ds_after: got %h want bd=0", dut_v);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0, 32'h4000 + i, $urandom, 0, 1);
            n_checks++;
            if (dut_v !== {32'h300c, 32'h2403_0001, 5'd0, 1'b0, 1'b1}) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got %h want frozen 300c", i, dut_v);
            end
        end
        step(0, 1, 0, 1, 0, 32'h3010, 32'h2404_0002, 0, 0);
        n_checks++;
        if (dut_v !== {32'h3010, 32'h0, 5'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL flush_in_stall: got %h want bubble pc 3010", dut_v);
        end
        step(0, 0, 0, 1, 0, 32'h3014, 32'h2405_0003, 0, 0);
        n_checks++;
        if (dut_v !== {32'h3010, 32'h0, 5'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL bubble_hold: got %h want bubble pc 3010", dut_v);
        end
    endtask

    task automatic test_eret_kill();
        step(0, 0, 0, 0, 0, 32'h3020, 32'h4200_0018, 0, 0);
        step(0, 0, 0, 1, 1, 32'h3024, 32'h2402_0005, 0, 0);
        n_checks++;
        if (dut_v !== {32'h3020, 32'h4200_0018, 5'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL eret_stall_hold: got %h want held eret", dut_v);
        end
        step(0, 0, 0, 0, 1, 32'h3024, 32'h2402_0005, 0, 0);
        n_checks++;
        if (dut_v !== {32'h3024, 32'h0, 5'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL eret_kill: got %h want bubble pc 3024", dut_v);
        end
        // Kill after a branch: bubble must not hand the slot flag onward.
        step(0, 0, 0, 0, 0, 32'h3028, 32'h1000_0001, 0, 1);
        step(0, 0, 1, 0, 0, 32'h302c, 32'h0, 0, 0);
        step(0, 0, 0, 0, 0, 32'h3030, 32'h2406_0001, 0, 0);
        n_checks++;
        if (dut_v !== {32'h3030, 32'h2406_0001, 5'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL bubble_clears_bj: got %h want bd=0", dut_v);
        end
    endtask

    task automatic test_fetch_fault();
        step(0, 0, 0, 0, 0, 32'h3040, 32'hffff_ffff, 5'd4, 1);
        n_checks++;
        if (dut_v !== {32'h3040, 32'h0, 5'd4, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL fault: got %h want exc=4 instr=0 valid=1", dut_v);
        end
        step(0, 0, 0, 0, 0, 32'h3044, 32'h1000_0002, 0, 1);
        step(0, 0, 0, 0, 0, 32'h3048, 32'hffff_ffff, 5'd4, 1);
        n_checks++;
        if (dut_v !== {32'h3048, 32'h0, 5'd4, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL fault_in_slot: got %h want exc=4 bd=1", dut_v);
        end
        step(0, 0, 0, 0, 0, 32'h304c, 32'h2407_0001, 0, 0);
        n_checks++;
        if (dut_v !== {32'h304c, 32'h2407_0001, 5'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL after_fault: got %h want bd=0", dut_v);
        end
    endtask

    task automatic test_ri();
        logic [70:0] want;
        step(0, 0, 0, 0, 0, 32'h3050, 32'hfc00_0000, 0, 0);
        want = ri_check_on() ? {32'h3050, 32'h0, 5'd10, 1'b0, 1'b1}
                             : {32'h3050, 32'hfc00_0000, 5'd0, 1'b0, 1'b1};
        n_checks++;
        if (dut_v !== want) begin
            n_fail++; $display("FAIL ri_word: got %h want %h", dut_v, want);
        end
    endtask

    task automatic test_reset_mid_stall();
        step(0, 0, 0, 1, 0, 32'h3060, 32'h1, 0, 0);
        step(1, 1, 0, 1, 1, 32'h3064, 32'h2, 0, 1);
        n_checks++;
        if (dut_v !== {RESET_PC, 32'h0, 5'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL reset_mid_stall: got %h want reset values", dut_v);
        end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [31:0] pc = 32'h3000;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: ins = $urandom;
                1: ins = {6'h09, 26'($urandom)};
                2: ins = {6'h00, 20'($urandom), 6'h21};
                default: ins = {6'h3f, 26'($urandom)};
            endcase
            step($urandom_range(0, 63) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 7) == 0, pc, ins,
                 ($urandom_range(0, 7) == 0) ? 5'd4 : 5'd0, $urandom_range(0, 3) == 0);
            pc = pc + 4;
            n_checks++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", i, dut_v, mdl_v);
            end
        end
    endtask

    initial begin
        reset = 1; stall = 0; flush_exc = 0; flush_eret = 0; eret_id = 0;
        pc_in = 0; instr_in = 0; exc_code_in = 0; bd_in = 0;
        m_pc = RESET_PC; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0; m_pbj = 0;
        test_reset();
        test_basic_load();
        test_delay_slot();
        test_stall();
        test_eret_kill();
        test_fetch_fault();
        test_ri();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_id_reg.md
# if_id_reg

Pipeline register between the fetch stage and the decode stage of the five-stage MIPS core with CP0 exception support. Each cycle it captures the fetched PC, instruction word, fetch exception code and branch-delay flag, and presents them to decode. It implements hold on stall, bubble insertion on exception entry and on `eret`, and kills the instruction fetched behind an `eret` in decode. It also sanitises faulting fetches so decode never executes a garbage word.

## Interface
- `RESET_PC`, default `32'h0000_3000`: PC value driven on `pc_out` while in reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  decode-stage hazard stall; hold the current contents.
- `flush_exc`  in  1  exception or interrupt taken this cycle; insert a bubble.
- `flush_eret`  in  1  `eret` in memory stage redirecting fetch; insert a bubble.
- `eret_id`  in  1  instruction currently in decode is `eret`.
- `pc_in`  in  32  fetch PC.
- `instr_in`  in  32  fetched instruction word.
- `exc_code_in`  in  5  fetch exception code: 0 = none, 4 = AdEL.
- `bd_in`  in  1  fetched instruction is a branch or jump; its successor is a delay slot.
- `pc_out`  out  32  registered PC.
- `instr_out`  out  32  registered instruction; `32'h0` for a bubble.
- `exc_code_out`  out  5  registered exception code.
- `bd_out`  out  1  registered instruction sits in a delay slot.
- `valid_out`  out  1  1 = real instruction, 0 = bubble.

## Operation
- Internal state: the output registers plus `prev_bj`, which is 1 when the last latched valid instruction was a branch or jump.
- Per-edge priority, highest first: reset > `flush_exc` > `flush_eret` > `stall` > `eret_id` kill > normal load.
- **Reset**
  - `pc_out` = RESET_PC.
  - `instr_out` = 0, `exc_code_out` = 0, `bd_out` = 0, `valid_out` = 0, `prev_bj` = 0.
- **Bubble** (`flush_exc` or `flush_eret`)
  - `instr_out` = 0, `exc_code_out` = 0, `bd_out` = 0, `valid_out` = 0, `prev_bj` = 0.
  - `pc_out` loads `pc_in`, so the macroscopic PC of the bubble tracks fetch.
  - A flush overrides `stall`.
- **Stall**: all registers, including `prev_bj`, hold.
- **eret kill** (`eret_id` = 1, no stall, no flush)
  - Load a bubble exactly as above; `pc_out` = `pc_in`.
  - `eret` has no delay slot, so the word fetched behind it must never execute.
- **Normal load**
  - `pc_out` = `pc_in`, `valid_out` = 1.
  - `bd_out` = `prev_bj`.
  - `prev_bj` = `bd_in`.
- **Fetch fault** (normal load with `exc_code_in` != 0)
  - `instr_out` = 0; `exc_code_out` = `exc_code_in`.
  - `bd_out` is computed as normal, so EPC adjustment still works.
  - `prev_bj` = 0: a faulting word is never a branch.
- **Clean fetch** (normal load with `exc_code_in` = 0): `instr_out` = `instr_in`, `exc_code_out` = 0, subject to Configuration.
- A bubble does not consume a delay slot: `prev_bj` clears on every bubble.

## Timing
- Latency is one cycle from `*_in` to `*_out`; no combinational path from inputs to outputs.
- `stall` asserted for N cycles holds the outputs N cycles; the fetched word is re-presented by fetch, which also holds its PC.
- `flush_exc` and `stall` in the same cycle: a bubble is loaded. The next cycle holds the bubble if `stall` persists.
- `flush_eret` and `flush_exc` in the same cycle: behaviour is identical (bubble).
- Reset asserted mid-stall or mid-flush: reset values load on that edge.

## Configuration
- `IFID_RI_CHECK_EN` defined: on a clean normal load, the word is matched against the supported set:
  - R-type `funct` addu, subu, and, or, slt, sltu, sll, srl, sra, jr, jalr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo, and the `32'h0` nop.
  - Opcodes addi, addiu, andi, ori, xori, lui, slti, sltiu, lw, lh, lhu, lb, lbu, sw, sh, sb, beq, bne, blez, bgtz, bltz, bgez, j, jal.
  - COP0 mfc0, mtc0, `eret`.
  - On a miss: `exc_code_out` = 10 (RI), `instr_out` = 0, `prev_bj` = 0, `valid_out` = 1.
- Not defined: the word passes through unchanged and decode raises RI.

## Test plan
- Reset, then load `pc_in`=0x3000, `instr_in`=0x34010001 -> next cycle `pc_out`=0x3000, `instr_out`=0x34010001, `valid_out`=1, `bd_out`=0.
- Load beq (`bd_in`=1) at 0x3004, then ori at 0x3008 -> ori has `bd_out`=1; the following instruction has `bd_out`=0.
- `stall` high 3 cycles with inputs changing -> outputs frozen at prior values; `flush_exc` during a stall -> bubble next edge: `instr_out`=0, `valid_out`=0.
- `eret_id`=1 with `instr_in`=0x24020005 -> `instr_out`=0, `valid_out`=0; with `stall`=1 as well -> hold.
- `exc_code_in`=4, `instr_in`=0xFFFFFFFF -> `exc_code_out`=4, `instr_out`=0, `valid_out`=1.
- With `IFID_RI_CHECK_EN`, `instr_in`=0xFC000000 -> `exc_code_out`=10, `instr_out`=0; without the macro -> `instr_out`=0xFC000000, `exc_code_out`=0.
